write_buffer: RTL and testbench
===============================

Name: write_buffer

Overview:
- Write-through buffer between the CACHE/CPU write path and RAM.
- Queues CPU store traffic (address and data) and drains it to RAM with a req/ack handshake, so a store completes in one cycle and does not wait for the memory latency.
- Gives the cache's read-miss path a block-level conflict flag, so a line fill never reads stale RAM.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width (one word).
- DEPTH, 4, number of entries; power of 2, at least 2.
- OFFSET_BITS, 4, block-offset bits; a block is 16 bytes and matches the cache line.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- push_valid  in  1  store request from the CPU/cache write path.
- push_ready  out  1  buffer can accept a store; equals !full.
- push_addr  in  AW  store byte address.
- push_data  in  DW  store data.
- mem_req  out  1  head entry presented to RAM.
- mem_addr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ack  in  1  RAM accepted the head write this cycle.
- chk_addr  in  AW  read-miss address from the cache.
- chk_conflict  out  1  some valid entry lies in the same block as chk_addr.
- empty  out  1  no valid entries.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (clr=0, asynchronous):
  - head/tail pointers go to 0, count to 0, all valid bits clear.
  - empty=1, full=0, push_ready=1, mem_req=0, chk_conflict=0.
  - mem_addr and mem_wdata go to 0.
- Reset mid-operation: pending writes are discarded; mem_req drops immediately, without waiting for a clock edge.
- Storage:
  - circular FIFO of {addr, data, valid}.
  - tail pointer for writes, head pointer for drain.
  - pointers wrap modulo DEPTH.
- Push: accepted at a rising edge when push_valid && push_ready.
  - Coalesce case: applies when count >= 2 and push_addr[AW-1:2] equals the tail-1 entry's word address. Overwrite that entry's data; count is unchanged.
  - Otherwise write a new entry at tail, advance tail, count+1.
  - The head entry is never coalesced, because it is in flight to RAM.
- Drain:
  - mem_req = !empty, driven from registered state.
  - mem_addr and mem_wdata = head entry, held stable until mem_ack is sampled high.
  - On clk edge with mem_req && mem_ack: invalidate head, advance head, count-1.
  - Back-to-back: the next entry is presented in the cycle after the ack, with no idle cycle.
  - mem_ack while mem_req=0 is ignored.
- Latency: a push into an empty buffer appears on mem_req in the next cycle.
- Simultaneous push and pop:
  - count is unchanged (coalesce+pop gives count-1).
  - When full, push_ready=0 even if a pop occurs in the same cycle; there is no bypass.
- chk_conflict:
  - combinational OR over valid entries of (entry.addr[AW-1:OFFSET_BITS] == chk_addr[AW-1:OFFSET_BITS]).
  - The cache must stall its line fill while this is 1.
  - An entry is still counted on the cycle its ack arrives; it clears the following cycle.
- Ordering: RAM sees stores in push order; coalescing keeps only the last data written to a word.

Decomposition:
- Package wb_pkg:
  - wb_entry_t struct {valid, addr, data}.
  - default constants for AW, DW, DEPTH, OFFSET_BITS.
  - function blk_of(addr) returning the block address.
- One sub-module, wb_match: a combinational DEPTH-wide block comparator array producing the conflict vector. It is reused for the coalesce compare in word mode, selected by a mode input.

Test Plan:
- Reset, then push 0x00000001/10, 0x00000012/20, 0x00040030/30 with mem_ack held 0.
  - count=3 and mem_addr=0x00000001.
  - Raise mem_ack for 3 cycles: RAM receives 10, 20, 30 in order; afterwards empty=1 and mem_req=0.
- Fill 4 entries with mem_ack=0, then push again.
  - full=1, push_ready=0, and the 5th push is not stored.
  - Assert mem_ack once: full drops the next cycle and a new push is accepted.
- Pending entry 0x00040030/40, then set chk_addr=0x00040034.
  - chk_conflict=1 (same block); chk_addr=0x000C0034 gives 0.
  - After 0x00040030 is acked, chk_conflict=0 in the next cycle.
- Two entries pending (head 0x00000012/20, tail 0x000C0034/50), then push 0x000C0034/60.
  - count stays 2 and RAM later receives 60 for 0x000C0034.
  - Pushing 0x00000012/70 instead appends a new entry (head is not coalesced): count=3.
- Push and ack in the same cycle with count=2: count stays 2 and the order is preserved.
- Assert clr=0 asynchronously mid-drain, between clock edges, with 3 entries pending.
  - mem_req, count and chk_conflict drop to 0 immediately.
  - After release, the next push 0x00000001/10 is the only write RAM sees.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write buffer: entry layout, default geometry,
// and address-to-block reduction used by the comparator array.
package wb_pkg;

    localparam int WB_AW          = 32;
    localparam int WB_DW          = 32;
    localparam int WB_DEPTH       = 4;
    localparam int WB_OFFSET_BITS = 4;
    localparam int WB_WORD_BITS   = 2;

    typedef struct packed {
        logic             valid;
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        MATCH_BLOCK = 1'b0,
        MATCH_WORD  = 1'b1
    } match_mode_e;

    function automatic logic [WB_AW-1:0] blk_of(input logic [WB_AW-1:0] addr, input int unsigned off);
        return addr >> off;
    endfunction

endpackage

// File: rtl/wb_match.sv
// Combinational comparator array: flags every valid entry whose address falls in
// the same block (or same word, in word mode) as the probe address.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH       = WB_DEPTH,
    parameter int OFFSET_BITS = WB_OFFSET_BITS
) (
    input  match_mode_e      mode_i,
    input  logic [WB_AW-1:0] addr_i,
    input  wb_entry_t        entries_i [DEPTH],
    output logic [DEPTH-1:0] hit_o
);

    // Per-entry address compare at the granularity selected by mode_i
    always_comb begin
        hit_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (mode_i)
                MATCH_BLOCK: hit_o[i] = entries_i[i].valid &&
                    (blk_of(entries_i[i].addr, OFFSET_BITS) == blk_of(addr_i, OFFSET_BITS));
                MATCH_WORD:  hit_o[i] = entries_i[i].valid &&
                    (blk_of(entries_i[i].addr, WB_WORD_BITS) == blk_of(addr_i, WB_WORD_BITS));
                default:     hit_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Write-through store buffer: queues CPU stores, drains them to RAM over req/ack,
// coalesces repeat stores to the newest non-head word, and flags read-miss conflicts.
module write_buffer
    import wb_pkg::*;
#(
    parameter int AW          = WB_AW,
    parameter int DW          = WB_DW,
    parameter int DEPTH       = WB_DEPTH,
    parameter int OFFSET_BITS = WB_OFFSET_BITS
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    input  logic [AW-1:0]            chk_addr,
    output logic                     chk_conflict,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        ent_q [DEPTH];
    wb_entry_t        ent_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] blk_hit_s;
    logic [DEPTH-1:0] word_hit_s;
    logic [PW-1:0]    last_idx_s;
    logic             push_fire_s;
    logic             pop_s;
    logic             coal_s;
    logic             inc_s;

    wb_match #(.DEPTH(DEPTH), .OFFSET_BITS(OFFSET_BITS)) u_blk_match (
        .mode_i    (MATCH_BLOCK),
        .addr_i    (chk_addr),
        .entries_i (ent_q),
        .hit_o     (blk_hit_s)
    );

    wb_match #(.DEPTH(DEPTH), .OFFSET_BITS(OFFSET_BITS)) u_word_match (
        .mode_i    (MATCH_WORD),
        .addr_i    (push_addr),
        .entries_i (ent_q),
        .hit_o     (word_hit_s)
    );

    assign empty        = (count_q == CW'(0));
    assign full         = (count_q == CW'(DEPTH));
    assign count        = count_q;
    assign push_ready   = !full;
    assign mem_req      = !empty;
    assign mem_addr     = ent_q[head_q].addr;
    assign mem_wdata    = ent_q[head_q].data;
    assign chk_conflict = |blk_hit_s;

    assign last_idx_s  = tail_q - PW'(1);
    assign push_fire_s = push_valid && push_ready;
    assign pop_s       = mem_req && mem_ack;
    // With two or more entries the newest one is never the in-flight head
    assign coal_s      = (count_q >= CW'(2)) && word_hit_s[last_idx_s];
    assign inc_s       = push_fire_s && !coal_s;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_s) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (push_fire_s && coal_s) begin
            ent_d[last_idx_s].data = push_data;
        end else if (push_fire_s) begin
            ent_d[tail_q] = '{valid: 1'b1, addr: push_addr, data: push_data};
            tail_d        = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({inc_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; clearing here also drops mem_req and chk_conflict at once
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a queue model predicts RAM writes, occupancy,
// handshake flags and block conflicts; every comparison goes through check_eq.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_addr = 32'h0;
    logic [31:0] push_data = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] chk_addr = 32'h0;
    logic        chk_conflict;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    write_buffer dut (
        .clk          (clk),
        .clr          (clr),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_addr    (push_addr),
        .push_data    (push_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .chk_addr     (chk_addr),
        .chk_conflict (chk_conflict),
        .empty        (empty),
        .full         (full),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: check DUT against the model at the falling edge, update the model
    // for the coming rising edge, and return 1 time unit after that edge.
    task automatic cycle();
        logic pre_req;
        logic conf;
        logic acc;
        @(negedge clk);
        pre_req = (q.size() != 0);
        conf = 1'b0;
        foreach (q[i]) if (q[i].a[31:4] == chk_addr[31:4]) conf = 1'b1;
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("mem_req", 64'(mem_req), 64'(pre_req));
        check_eq("push_ready", 64'(push_ready), 64'(q.size() < 4));
        check_eq("conflict", 64'(chk_conflict), 64'(conf));
        if (pre_req) begin
            check_eq("mem_addr", 64'(mem_addr), 64'(q[0].a));
            check_eq("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
        end
        acc = push_valid && (q.size() < 4);
        if (acc) begin
            if (q.size() >= 2 && q[q.size()-1].a[31:2] == push_addr[31:2])
                q[q.size()-1].d = push_data;
            else
                q.push_back('{a: push_addr, d: push_data});
        end
        if (pre_req && mem_ack) void'(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        cycle();
        push_valid = 1'b0;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        mem_ack = 1'b0;
        check_eq("drain_done", 64'(q.size()), 64'd0);
        cycle();
        check_eq("drained_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        #12;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        cycle();

        // Basic ordering: three stores, then drain back-to-back
        push(32'h0000_0001, 32'd10);
        push(32'h0000_0012, 32'd20);
        push(32'h0004_0030, 32'd30);
        check_eq("three_count", 64'(count), 64'd3);
        check_eq("three_head", 64'(mem_addr), 64'h0000_0001);
        drain();

        // Full buffer rejects a fifth store until one drains
        push(32'h0000_0100, 32'd1);
        push(32'h0000_0200, 32'd2);
        push(32'h0000_0300, 32'd3);
        push(32'h0000_0400, 32'd4);
        check_eq("full_flag", 64'(full), 64'd1);
        push(32'h0000_0500, 32'd5);
        check_eq("full_count", 64'(count), 64'd4);
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        check_eq("full_dropped", 64'(full), 64'd0);
        push(32'h0000_0600, 32'd6);
        check_eq("refill_count", 64'(count), 64'd4);
        drain();

        // Block conflict on a pending entry, clearing the cycle after its ack
        push(32'h0004_0030, 32'd40);
        chk_addr = 32'h0004_0034;
        cycle();
        check_eq("conf_same_blk", 64'(chk_conflict), 64'd1);
        chk_addr = 32'h000C_0034;
        cycle();
        check_eq("conf_other_blk", 64'(chk_conflict), 64'd0);
        chk_addr = 32'h0004_0034;
        mem_ack  = 1'b1;
        cycle();
        mem_ack  = 1'b0;
        check_eq("conf_after_ack", 64'(chk_conflict), 64'd0);
        cycle();

        // Coalescing into the newest entry, never into the head
        push(32'h0000_0012, 32'd20);
        push(32'h000C_0034, 32'd50);
        push(32'h000C_0034, 32'd60);
        check_eq("coal_count", 64'(count), 64'd2);
        push(32'h0000_0012, 32'd70);
        check_eq("append_count", 64'(count), 64'd3);
        drain();
        push(32'h0000_0012, 32'd20);
        push(32'h0000_0012, 32'd70);
        check_eq("head_no_coal", 64'(count), 64'd2);
        drain();

        // Simultaneous push and pop keeps occupancy
        push(32'h0000_0001, 32'd1);
        push(32'h0000_0100, 32'd2);
        mem_ack = 1'b1;
        push(32'h0000_0200, 32'd3);
        mem_ack = 1'b0;
        check_eq("pushpop_count", 64'(count), 64'd2);
        drain();

        // Asynchronous reset mid-drain discards everything
        push(32'h0000_0100, 32'd7);
        push(32'h0000_0200, 32'd8);
        push(32'h0000_0300, 32'd9);
        chk_addr = 32'h0000_0104;
        mem_ack  = 1'b1;
        cycle();
        #2;
        clr = 1'b0;
        #1;
        check_eq("arst_mem_req", 64'(mem_req), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_conflict", 64'(chk_conflict), 64'd0);
        q.delete();
        @(negedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        push(32'h0000_0001, 32'd10);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        mem_ack = 1'b0;
        check_eq("post_rst_empty", 64'(q.size()), 64'd0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
